bcd_display_driver: RTL

BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

---
 rtl/display_pkg.sv | 37 +++
 rtl/bin2bcd.sv | 89 ++++++++
 rtl/bcd_display_driver.sv | 91 +++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the BCD display driver.
//   conv_state_e : double-dabble converter states
//   SEG_TABLE    : active-low {g,f,e,d,c,b,a} patterns, index 0-9 are digits, 10 is blank
//   SEG_BLANK    : all segments off
//   seg_encode() : nibble to segment pattern, non-decimal nibbles blank
package display_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [10:0][6:0] SEG_TABLE = {
    SEG_BLANK,   // 10
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    if (d > 4'd9) begin
      return SEG_BLANK;
    end
    return SEG_TABLE[d];
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble binary to BCD converter.
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   number : binary input, sampled once per conversion in the idle cycle
//   bcd    : BCD result of the last completed conversion, digit 0 in [3:0]
//   busy   : high while shifting or writing back the result
// Conversions run back to back: one sample cycle, BITS shift cycles, one write-back cycle.
module bin2bcd
  import display_pkg::*;
#(
  parameter int unsigned BITS   = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BITS-1:0]       number,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(BITS + 1);

  conv_state_e               state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [BITS-1:0]           sr_q, sr_d;
  logic [4*DIGITS-1:0]       scratch_q, scratch_d;
  logic [4*DIGITS-1:0]       bcd_q, bcd_d;
  logic [4*DIGITS-1:0]       adj;

  always_comb begin
    // Add-3 correction on every nibble that would overflow past 9 after the shift.
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end

    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;

    unique case (state_q)
      StIdle: begin
        sr_d      = number;
        scratch_d = '0;
        cnt_d     = '0;
        state_d   = StShift;
      end
      StShift: begin
        scratch_d = {adj[4*DIGITS-2:0], sr_q[BITS-1]};
        sr_d      = sr_q << 1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(BITS - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcd_d   = scratch_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sr_q      <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
    end
  end

  assign bcd  = bcd_q;
  assign busy = (state_q != StIdle);

endmodule

// File: rtl/bcd_display_driver.sv
// Multiplexed 7-segment driver for a binary value.
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   number : binary value to display
//   bcd    : latched BCD of the last converted value
//   busy   : converter activity
//   an     : active-low digit enables, exactly one low
//   seg    : active-low {g,f,e,d,c,b,a} for the enabled digit
// Each digit is enabled for SCAN_DIV cycles in turn. Leading zeros above digit 0 are
// optionally blanked.
module bcd_display_driver
  import display_pkg::*;
#(
  parameter int unsigned BITS     = 8,
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BITS-1:0]       number,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SW-1:0]     scan_q, scan_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] lz;
  logic              zero_above;
  logic [3:0]        cur;
  logic              cur_lz;

  bin2bcd #(
    .BITS   (BITS),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .number (number),
    .bcd    (bcd),
    .busy   (busy)
  );

  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
    end
  end

  always_comb begin
    // lz[i] is set when digit i and every digit above it are zero.
    zero_above = 1'b1;
    lz         = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (bcd[4*i +: 4] == 4'd0);
      lz[i]      = zero_above;
    end

    cur    = 4'd0;
    cur_lz = 1'b0;
    an     = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        an[i]  = 1'b0;
        cur    = bcd[4*i +: 4];
        cur_lz = lz[i] && (i != 0);
      end
    end

    seg = ((BLANK_LZ != 0) && cur_lz) ? SEG_BLANK : seg_encode(cur);
  end

endmodule
